// File: rtl/apb_reg_slave.sv
// ---------------------------------------------------------------------------
// apb_reg_slave
//   APB slave with DEPTH byte-wide registers and a programmable number of
//   wait states. Each transfer is latched in the setup phase, then walks
//   IDLE -> (WAIT x WAIT_CYCLES) -> READY -> IDLE. Every response output
//   comes straight from a flop, so no combinational path runs from the bus
//   inputs to prdata/pready/pslverr.
//
// Parameters
//   WAIT_CYCLES : wait states before pready (0-15)
//   DEPTH       : number of implemented byte registers (1-16)
//   SEL_NIBBLE  : paddr[7:4] value decoded by this slave
//
// Ports
//   pclk    in   APB clock, rising edge
//   preset  in   asynchronous active-high reset
//   psel    in   slave select
//   penable in   access phase
//   pwrite  in   1 = write, 0 = read
//   paddr   in   [7:4] region, [3:0] register offset
//   pwdata  in   write data
//   prdata  out  read data (0 unless a good read is in READY)
//   pready  out  transfer complete, one cycle
//   pslverr out  error response, only together with pready
// ---------------------------------------------------------------------------
module apb_reg_slave #(
    parameter int         WAIT_CYCLES = 1,
    parameter int         DEPTH       = 12,
    parameter logic [3:0] SEL_NIBBLE  = 4'h0
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        READY = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic       wr_q, wr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic       pready_q, pready_d;
    logic       pslverr_q, pslverr_d;
    logic [7:0] prdata_q, prdata_d;
    logic [7:0] rd_byte;
    logic       mem_we;

    // Region mismatch or offset beyond the implemented registers.
    function automatic logic addr_err(input logic [7:0] a);
        return (a[7:4] != SEL_NIBBLE) || ({1'b0, a[3:0]} >= 5'(DEPTH));
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                // penable without a preceding setup phase is ignored here.
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = READY;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = READY;
                end
            end
            READY: begin
                // A new setup seen here is dropped; only IDLE accepts one.
                state_d = IDLE;
                if (psel && penable && wr_q && !addr_err(addr_q)) mem_we = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (mem_we && addr_q[3:0] == 4'(i)) mem_d[i] = wdata_q;
        end

        // Read mux looks at the address about to be held in READY. Storage
        // is only written when leaving READY, so it is stable here.
        rd_byte = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_d[3:0] == 4'(i)) rd_byte = mem_q[i];
        end

        pready_d  = (state_d == READY);
        pslverr_d = pready_d && addr_err(addr_d);
        prdata_d  = (pready_d && !wr_d && !addr_err(addr_d)) ? rd_byte : 8'h00;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 8'h00;
            wr_q      <= 1'b0;
            wdata_q   <= 8'h00;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_slave
//   Three slaves (0, 1 and 3 wait states) share the APB address/data lines,
//   each with its own psel. A per-slave byte array tracks what each register
//   file should hold; expected latency is simply wait states + 1 access
//   cycles, and errors come from the address decode rules.
// ---------------------------------------------------------------------------
module tb_apb_reg_slave;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       psel [3];
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata [3];
    logic       pready [3];
    logic       pslverr [3];

    int         wc [3] = '{0, 1, 3};
    logic [7:0] model [3][16];
    int         checks = 0;
    int         fails = 0;

    always #5 pclk = ~pclk;

    apb_reg_slave #(.WAIT_CYCLES(0)) u_wc0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));
    apb_reg_slave #(.WAIT_CYCLES(1)) u_wc1 (
        .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));
    apb_reg_slave #(.WAIT_CYCLES(3)) u_wc3 (
        .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    function automatic bit exp_err(input logic [7:0] a);
        return (a[7:4] != 4'h0) || (a[3:0] > 4'd11);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) model[k][i] = 8'h00;
    endtask

    // One full transfer on slave k; returns with psel/penable still high,
    // sampled in the cycle where pready was seen (or on timeout).
    task automatic xfer(input int k, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output logic er, output int cyc);
        @(negedge pclk);
        for (int j = 0; j < 3; j++) psel[j] = (j == k);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        cyc = 1;
        while (pready[k] !== 1'b1) begin
            checks++;
            if (pslverr[k] !== 1'b0 || prdata[k] !== 8'h00) begin
                fails++;
                $display("FAIL wait_outputs slave%0d: pslverr=%b prdata=%h, required 0/00", k, pslverr[k], prdata[k]);
            end
            if (cyc >= 40) begin
                checks++; fails++;
                $display("FAIL timeout slave%0d addr=%h: no pready in 40 cycles", k, a);
                break;
            end
            @(negedge pclk);
            cyc++;
        end
        rd = prdata[k];
        er = pslverr[k];
        if (wr && !exp_err(a)) model[k][a[3:0]] = d;
    endtask

    task automatic idle();
        @(negedge pclk);
        for (int j = 0; j < 3; j++) psel[j] = 1'b0;
        penable = 1'b0;
    endtask

    // Runs a transfer and compares latency, error and read data to the model.
    task automatic check_xfer(input string nm, input int k, input bit wr,
                              input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rd, exp_d;
        logic er;
        int cyc;
        bit ee;
        ee = exp_err(a);
        exp_d = (wr || ee) ? 8'h00 : model[k][a[3:0]];
        xfer(k, wr, a, d, rd, er, cyc);
        checks++;
        if (cyc !== wc[k] + 1) begin
            fails++;
            $display("FAIL %s latency slave%0d addr=%h: got %0d cycles, required %0d", nm, k, a, cyc, wc[k] + 1);
        end
        checks++;
        if (er !== ee) begin
            fails++;
            $display("FAIL %s pslverr slave%0d addr=%h: got %b, required %b", nm, k, a, er, ee);
        end
        checks++;
        if (rd !== exp_d) begin
            fails++;
            $display("FAIL %s prdata slave%0d addr=%h wr=%b: got %h, required %h", nm, k, a, wr, rd, exp_d);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 8'h00) begin
                fails++;
                $display("FAIL reset_outputs slave%0d: pready=%b pslverr=%b prdata=%h, required 0/0/00", k, pready[k], pslverr[k], prdata[k]);
            end
        end
    endtask

    task automatic test_basic_rw();
        check_xfer("wr_a5", 1, 1'b1, 8'h03, 8'hA5);
        check_xfer("rd_a5", 1, 1'b0, 8'h03, 8'h00);
        check_xfer("wr_3c", 0, 1'b1, 8'h0B, 8'h3C);
        check_xfer("rd_3c", 0, 1'b0, 8'h0B, 8'h00);
        idle();
    endtask

    task automatic test_errors();
        check_xfer("wr_oob", 1, 1'b1, 8'h0C, 8'hFF);
        check_xfer("rd_oob", 1, 1'b0, 8'h0C, 8'h00);
        for (int i = 0; i < 12; i++) check_xfer("scan", 1, 1'b0, 8'(i), 8'h00);
        check_xfer("rd_region", 1, 1'b0, 8'h15, 8'h00);
        check_xfer("rd_05", 1, 1'b0, 8'h05, 8'h00);
        check_xfer("wr_region", 2, 1'b1, 8'hF3, 8'h9E);
        check_xfer("rd_f_off", 2, 1'b0, 8'h0F, 8'h00);
        idle();
    endtask

    task automatic test_abort();
        @(negedge pclk);
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h77;
        @(negedge pclk);
        penable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pready[2] !== 1'b0) begin
                fails++;
                $display("FAIL abort_wait pready: got %b, required 0", pready[2]);
            end
            @(negedge pclk);
        end
        psel[2] = 1'b0; penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            checks++;
            if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0) begin
                fails++;
                $display("FAIL abort_after pready/pslverr: got %b/%b, required 0/0", pready[2], pslverr[2]);
            end
        end
        check_xfer("rd_abort", 2, 1'b0, 8'h02, 8'h00);
        idle();
    endtask

    // Setup during READY is ignored, and penable in IDLE does nothing.
    task automatic test_protocol();
        logic [7:0] rd;
        logic er;
        int cyc;
        xfer(1, 1'b0, 8'h03, 8'h00, rd, er, cyc);
        penable = 1'b0; paddr = 8'h05;
        @(negedge pclk);
        psel[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            checks++;
            if (pready[1] !== 1'b0) begin
                fails++;
                $display("FAIL setup_in_ready pready: got %b, required 0", pready[1]);
            end
        end
        psel[1] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            checks++;
            if (pready[1] !== 1'b0) begin
                fails++;
                $display("FAIL penable_in_idle pready: got %b, required 0", pready[1]);
            end
        end
        idle();
        check_xfer("rd_after_proto", 1, 1'b0, 8'h03, 8'h00);
        idle();
    endtask

    task automatic test_reset_mid();
        check_xfer("wr_11", 1, 1'b1, 8'h04, 8'h11);
        @(negedge pclk);
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h22;
        @(negedge pclk);
        penable = 1'b1;
        #2 preset = 1'b1;
        #1;
        checks++;
        if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || prdata[1] !== 8'h00) begin
            fails++;
            $display("FAIL reset_in_wait outputs: %b/%b/%h, required 0/0/00", pready[1], pslverr[1], prdata[1]);
        end
        @(negedge pclk);
        preset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        clear_model();
        check_xfer("rd_after_rst", 1, 1'b0, 8'h04, 8'h00);
        check_xfer("wr_5a", 1, 1'b1, 8'h04, 8'h5A);
        idle();
        // Reset while a good read is being presented.
        @(negedge pclk);
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        checks++;
        if (pready[1] !== 1'b1 || prdata[1] !== 8'h5A) begin
            fails++;
            $display("FAIL ready_before_rst: pready=%b prdata=%h, required 1/5a", pready[1], prdata[1]);
        end
        #2 preset = 1'b1;
        #1;
        checks++;
        if (pready[1] !== 1'b0 || prdata[1] !== 8'h00) begin
            fails++;
            $display("FAIL reset_in_ready outputs: pready=%b prdata=%h, required 0/00", pready[1], prdata[1]);
        end
        @(negedge pclk);
        preset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        clear_model();
        check_xfer("rd_after_rst2", 1, 1'b0, 8'h04, 8'h00);
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 120; n++) begin
            int k;
            bit wr;
            logic [7:0] a;
            k = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            a[3:0] = 4'($urandom_range(0, 15));
            a[7:4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            check_xfer("random", k, wr, a, 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 12; i++) check_xfer("final_scan", k, 1'b0, 8'(i), 8'h00);
        idle();
    endtask

    initial begin
        for (int j = 0; j < 3; j++) psel[j] = 1'b0;
        clear_model();
        repeat (3) @(negedge pclk);
        test_reset();
        preset = 1'b0;
        test_basic_rw();
        test_errors();
        test_abort();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
